// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, branch/jump
// flush, and a request/acknowledge FSM that freezes the pipeline during MEM accesses.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_Rt_i,
  input  logic [4:0]       IFID_Rs_i,
  input  logic [4:0]       IFID_Rt_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             EXMEM_MemRead_i,
  input  logic             EXMEM_MemWrite_i,
  input  logic             mem_ack_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFFlush_o,
  output logic             bubble_o,
  output logic             mem_req_o,
  output logic             mem_stall_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             err_o
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX  = WCNT_W'(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              err_q;
  logic              access, luse, req_raw, stall_raw;

  assign access = EXMEM_MemRead_i | EXMEM_MemWrite_i;
  assign luse   = IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
                  ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));

  always_comb begin
    state_d   = state_q;
    req_raw   = 1'b0;
    stall_raw = 1'b0;
    if (state_q == IDLE) begin
      if (access) begin
        req_raw   = 1'b1;
        stall_raw = 1'b1;
        state_d   = WAIT;
      end
    end else begin
      req_raw   = 1'b1;
      stall_raw = !mem_ack_i;
      if (mem_ack_i) state_d = IDLE;
    end
  end

  // The memory handshake is silenced for the whole time reset is held.
  assign mem_req_o   = req_raw & rst_i;
  assign mem_stall_o = stall_raw & rst_i;

  always_comb begin
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    IFFlush_o   = 1'b0;
    bubble_o    = 1'b0;
    if (mem_stall_o) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end else if (luse) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      bubble_o    = 1'b1;
    end else if (branch_taken_i || jump_i) begin
      IFFlush_o   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == WAIT) begin
        wait_cnt_q <= '0;
      end else if (state_q == WAIT && !mem_ack_i && wait_cnt_q != WAIT_MAX) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      // err rises on the edge where the wait count reaches TIMEOUT; the FSM keeps waiting.
      if (state_q == WAIT && !mem_ack_i && wait_cnt_q == WAIT_LAST) err_q <= 1'b1;
      if ((mem_stall_o || luse) && stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int MAXCNT  = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             IDEX_MemRead_i, branch_taken_i, jump_i;
  logic [4:0]       IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i;
  logic             EXMEM_MemRead_i, EXMEM_MemWrite_i, mem_ack_i;
  logic             PCWrite_o, IFIDWrite_o, IFFlush_o, bubble_o;
  logic             mem_req_o, mem_stall_o, err_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int errors = 0;
  int checks = 0;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_Rt_i(IDEX_Rt_i),
    .IFID_Rs_i(IFID_Rs_i), .IFID_Rt_i(IFID_Rt_i),
    .branch_taken_i(branch_taken_i), .jump_i(jump_i),
    .EXMEM_MemRead_i(EXMEM_MemRead_i), .EXMEM_MemWrite_i(EXMEM_MemWrite_i),
    .mem_ack_i(mem_ack_i),
    .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o), .IFFlush_o(IFFlush_o),
    .bubble_o(bubble_o), .mem_req_o(mem_req_o), .mem_stall_o(mem_stall_o),
    .stall_cnt_o(stall_cnt_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr();
    IDEX_MemRead_i = 1'b0; IDEX_Rt_i = 5'd0; IFID_Rs_i = 5'd0; IFID_Rt_i = 5'd0;
    branch_taken_i = 1'b0; jump_i = 1'b0;
    EXMEM_MemRead_i = 1'b0; EXMEM_MemWrite_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    step();
    step();
    rst_i = 1'b1;
  endtask

  // Behavioural model: an access is outstanding or not; count waited cycles and stalls.
  bit m_busy = 1'b0, m_err = 1'b0;
  int m_waited = 0, m_stalls = 0;

  initial begin
    bit acc, use_h, e_req, e_ms, e_pc, e_bub, e_fl;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        m_busy = 1'b0; m_err = 1'b0; m_waited = 0; m_stalls = 0;
      end
      acc   = EXMEM_MemRead_i || EXMEM_MemWrite_i;
      use_h = IDEX_MemRead_i && IDEX_Rt_i != 0 &&
              (IDEX_Rt_i == IFID_Rs_i || IDEX_Rt_i == IFID_Rt_i);
      if (!rst_i)       begin e_req = 1'b0; e_ms = 1'b0;       end
      else if (!m_busy) begin e_req = acc;  e_ms = acc;        end
      else              begin e_req = 1'b1; e_ms = !mem_ack_i; end
      e_pc  = !(e_ms || use_h);
      e_bub = !e_ms && use_h;
      e_fl  = !e_ms && !use_h && (branch_taken_i || jump_i);
      chk("mem_req",   int'(mem_req_o),   int'(e_req));
      chk("mem_stall", int'(mem_stall_o), int'(e_ms));
      chk("PCWrite",   int'(PCWrite_o),   int'(e_pc));
      chk("IFIDWrite", int'(IFIDWrite_o), int'(e_pc));
      chk("bubble",    int'(bubble_o),    int'(e_bub));
      chk("IFFlush",   int'(IFFlush_o),   int'(e_fl));
      chk("stall_cnt", int'(stall_cnt_o), m_stalls);
      chk("err",       int'(err_o),       int'(m_err));
      if (rst_i) begin
        if ((e_ms || use_h) && m_stalls < MAXCNT) m_stalls++;
        if (!m_busy) begin
          if (acc) begin m_busy = 1'b1; m_waited = 0; end
        end else if (mem_ack_i) begin
          m_busy = 1'b0;
        end else begin
          m_waited++;
          if (m_waited >= TIMEOUT) m_err = 1'b1;
        end
      end
    end
  end

  initial begin
    clr();
    rst_i = 1'b0;
    #1 EXMEM_MemRead_i = 1'b1;
    #2;
    chk("rst_req",   int'(mem_req_o),   0);
    chk("rst_stall", int'(mem_stall_o), 0);
    chk("rst_cnt",   int'(stall_cnt_o), 0);
    chk("rst_err",   int'(err_o),       0);
    step(); step();
    rst_i = 1'b1; clr();

    // load-use interlock, then the same pattern with r0 as destination
    IDEX_MemRead_i = 1'b1; IDEX_Rt_i = 5'd5; IFID_Rs_i = 5'd5; IFID_Rt_i = 5'd7;
    #2;
    chk("luse_pc",    int'(PCWrite_o),   0);
    chk("luse_ifid",  int'(IFIDWrite_o), 0);
    chk("luse_bub",   int'(bubble_o),    1);
    chk("luse_flush", int'(IFFlush_o),   0);
    chk("luse_cnt0",  int'(stall_cnt_o), 0);
    step();
    IDEX_Rt_i = 5'd0; IFID_Rs_i = 5'd0;
    #2;
    chk("luse_cnt1",  int'(stall_cnt_o), 1);
    chk("r0_pc",      int'(PCWrite_o),   1);
    chk("r0_bub",     int'(bubble_o),    0);
    step();
    chk("r0_cnt",     int'(stall_cnt_o), 1);

    clr(); branch_taken_i = 1'b1;
    #2;
    chk("br_flush", int'(IFFlush_o), 1);
    chk("br_pc",    int'(PCWrite_o), 1);
    step(); clr(); jump_i = 1'b1;
    #2;
    chk("jmp_flush", int'(IFFlush_o), 1);
    step(); clr();
    #2;
    chk("idle_flush", int'(IFFlush_o), 0);

    // load in MEM acked on the 4th cycle, taken branch frozen until the ack cycle
    do_reset();
    EXMEM_MemRead_i = 1'b1; branch_taken_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      mem_ack_i = 1'(c == 3);
      #2;
      chk("acc_req",   int'(mem_req_o),   1);
      chk("acc_stall", int'(mem_stall_o), int'(c < 3));
      chk("acc_flush", int'(IFFlush_o),   int'(c == 3));
      step();
    end
    clr();
    #2;
    chk("acc_idle",  int'(mem_req_o),   0);
    chk("acc_cnt",   int'(stall_cnt_o), 3);
    step();

    // timeout with no ack
    do_reset();
    EXMEM_MemWrite_i = 1'b1;
    step();
    for (int c = 0; c < TIMEOUT; c++) begin
      #2;
      chk("to_err_low", int'(err_o), 0);
      step();
    end
    #2;
    chk("to_err_high", int'(err_o),       1);
    chk("to_waiting",  int'(mem_stall_o), 1);
    mem_ack_i = 1'b1;
    step();
    clr();
    #2;
    chk("to_sticky", int'(err_o),     1);
    chk("to_idle",   int'(mem_req_o), 0);
    step(); step();
    chk("to_sticky2", int'(err_o), 1);
    do_reset();
    #2;
    chk("to_cleared", int'(err_o), 0);

    // asynchronous reset in the middle of WAIT, then a stray ack
    EXMEM_MemRead_i = 1'b1;
    step(); step();
    #2 rst_i = 1'b0;
    #1;
    chk("ar_req",   int'(mem_req_o),   0);
    chk("ar_stall", int'(mem_stall_o), 0);
    chk("ar_cnt",   int'(stall_cnt_o), 0);
    step();
    clr(); rst_i = 1'b1; mem_ack_i = 1'b1;
    #2;
    chk("stray_req", int'(mem_req_o), 0);
    chk("stray_pc",  int'(PCWrite_o), 1);
    step();
    mem_ack_i = 1'b0;
    #2;
    chk("stray_idle", int'(mem_req_o), 0);

    for (int i = 0; i < 4000; i++) begin
      rst_i            = 1'($urandom_range(0, 99) != 0);
      IDEX_MemRead_i   = 1'($urandom_range(0, 1));
      IDEX_Rt_i        = 5'($urandom_range(0, 3));
      IFID_Rs_i        = 5'($urandom_range(0, 3));
      IFID_Rt_i        = 5'($urandom_range(0, 3));
      branch_taken_i   = 1'($urandom_range(0, 3) == 0);
      jump_i           = 1'($urandom_range(0, 5) == 0);
      EXMEM_MemRead_i  = 1'($urandom_range(0, 2) == 0);
      EXMEM_MemWrite_i = 1'($urandom_range(0, 3) == 0);
      mem_ack_i        = 1'($urandom_range(0, 9) < 3);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
